// File: rtl/bcd_counter_modn.sv
// bcd_counter_modn: two-digit BCD modulo-N up/down counter with validated preset, TC and registered wrap pulse
module bcd_counter_modn #(
  parameter int MODULUS = 24
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       EN,
  input  logic       Up,
  input  logic       Load,
  input  logic [3:0] LdH,
  input  logic [3:0] LdL,
  output logic [3:0] CntH,
  output logic [3:0] CntL,
  output logic       TC,
  output logic       Co,
  output logic       LdErr
);
  localparam int MAX = MODULUS - 1;
  localparam logic [3:0] MAX_H = 4'(MAX / 10);
  localparam logic [3:0] MAX_L = 4'(MAX % 10);
  localparam logic [7:0] MAX_V = 8'(MAX);
  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("bcd_counter_modn: MODULUS must be within 2..100");
  end
  logic [3:0] r_h, r_l;
  logic       r_co, r_err;
  logic [7:0] w_val, w_ld_val;
  logic       w_legal, w_ld_ok, w_wrap;
  logic [3:0] w_nh, w_nl;
  assign w_val    = {4'd0, r_h} * 8'd10 + {4'd0, r_l};
  assign w_ld_val = {4'd0, LdH} * 8'd10 + {4'd0, LdL};
  assign w_legal  = (r_h <= 4'd9) && (r_l <= 4'd9) && (w_val <= MAX_V);
  assign w_ld_ok  = (LdH <= 4'd9) && (LdL <= 4'd9) && (w_ld_val <= MAX_V);
  assign TC       = EN && (Up ? (w_val == MAX_V) : (w_val == 8'd0));
  assign CntH     = r_h;
  assign CntL     = r_l;
  assign Co       = r_co;
  assign LdErr    = r_err;
  // Next count step; an illegal state collapses to 00 without a wrap
  always_comb begin
    w_nh   = 4'd0;
    w_nl   = 4'd0;
    w_wrap = 1'b0;
    if (!w_legal) begin
      w_nh = 4'd0;
    end else if (Up) begin
      if (w_val == MAX_V) w_wrap = 1'b1;
      else if (r_l == 4'd9) w_nh = r_h + 4'd1;
      else begin
        w_nh = r_h;
        w_nl = r_l + 4'd1;
      end
    end else begin
      if (w_val == 8'd0) begin
        w_wrap = 1'b1;
        w_nh   = MAX_H;
        w_nl   = MAX_L;
      end else if (r_l == 4'd0) begin
        w_nh = r_h - 4'd1;
        w_nl = 4'd9;
      end else begin
        w_nh = r_h;
        w_nl = r_l - 4'd1;
      end
    end
  end
  // Count state: load beats enable beats hold; Co marks the edge that wrapped
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      r_h   <= 4'd0;
      r_l   <= 4'd0;
      r_co  <= 1'b0;
      r_err <= 1'b0;
    end else if (Load) begin
      r_co <= 1'b0;
      if (w_ld_ok) begin
        r_h   <= LdH;
        r_l   <= LdL;
        r_err <= 1'b0;
      end else begin
        r_err <= 1'b1;
      end
    end else if (EN) begin
      r_h  <= w_nh;
      r_l  <= w_nl;
      r_co <= w_wrap;
    end else begin
      r_co <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bcd_counter_modn.sv
// tb_bcd_counter_modn: directed checks of mod-24 and cascaded mod-60 -> mod-24 stages
module tb_bcd_counter_modn;
  logic       CP = 1'b0, nCR = 1'b0;
  logic       en24 = 0, up24 = 1, ld24 = 0;
  logic [3:0] ldh24 = 0, ldl24 = 0;
  logic [3:0] h24, l24;
  logic       tc24, co24, err24;
  logic       en60 = 0, up60 = 1, ld60 = 0;
  logic [3:0] ldh60 = 0, ldl60 = 0;
  logic [3:0] h60, l60;
  logic       tc60, co60, err60;
  logic [3:0] hh, hl;
  logic       htc, hco, herr;
  int n_chk = 0, n_pass = 0;
  always #5 CP = ~CP;
  bcd_counter_modn #(.MODULUS(24)) u24 (
    .CP(CP), .nCR(nCR), .EN(en24), .Up(up24), .Load(ld24), .LdH(ldh24), .LdL(ldl24),
    .CntH(h24), .CntL(l24), .TC(tc24), .Co(co24), .LdErr(err24)
  );
  bcd_counter_modn #(.MODULUS(60)) u60 (
    .CP(CP), .nCR(nCR), .EN(en60), .Up(up60), .Load(ld60), .LdH(ldh60), .LdL(ldl60),
    .CntH(h60), .CntL(l60), .TC(tc60), .Co(co60), .LdErr(err60)
  );
  bcd_counter_modn #(.MODULUS(24)) u_hr (
    .CP(CP), .nCR(nCR), .EN(tc60), .Up(1'b1), .Load(1'b0), .LdH(4'd0), .LdL(4'd0),
    .CntH(hh), .CntL(hl), .TC(htc), .Co(hco), .LdErr(herr)
  );
  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction
  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CP);
    #1;
  endtask
  initial begin
    #12;
    check("rst_val", {h24, l24}, 0);
    check("rst_co", co24, 0);
    check("rst_err", err24, 0);
    nCR = 1; en24 = 1; up24 = 1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      check("up_val", {h24, l24}, bcd(i % 24));
      check("up_co", co24, int'(i == 24));
      if (i == 23) check("up_tc23", tc24, 1);
      if (i == 22) check("up_tc22", tc24, 0);
    end
    tick();
    check("up_01", {h24, l24}, 8'h01);
    check("co_drop", co24, 0);
    up24 = 0;
    tick();
    check("dn_00", {h24, l24}, 8'h00);
    check("dn_tc00", tc24, 1);
    tick();
    check("dn_wrap", {h24, l24}, 8'h23);
    check("dn_co", co24, 1);
    for (int i = 22; i >= 19; i--) begin
      tick();
      check("dn_val", {h24, l24}, bcd(i));
      check("dn_co0", co24, 0);
    end
    up24 = 1; tick();
    check("rev_up", {h24, l24}, 8'h20);
    en24 = 0; ld24 = 1; ldh24 = 1; ldl24 = 7; tick();
    check("ld17", {h24, l24}, 8'h17);
    check("ld17_err", err24, 0);
    ldh24 = 2; ldl24 = 5; tick();
    check("ld25_hold", {h24, l24}, 8'h17);
    check("ld25_err", err24, 1);
    ldh24 = 0; ldl24 = 4'hA; tick();
    check("ldA_hold", {h24, l24}, 8'h17);
    check("ldA_err", err24, 1);
    ldh24 = 0; ldl24 = 9; tick();
    check("ld09", {h24, l24}, 8'h09);
    check("ld09_err", err24, 0);
    ldh24 = 2; ldl24 = 3; tick();
    check("ld23_max", {h24, l24}, 8'h23);
    ldh24 = 1; ldl24 = 2; tick();
    en24 = 1; up24 = 1; ldh24 = 0; ldl24 = 5; tick();
    check("ld_pri", {h24, l24}, 8'h05);
    check("ld_pri_co", co24, 0);
    ld24 = 0; en24 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_val", {h24, l24}, 8'h05);
      check("hold_co", co24, 0);
      check("hold_tc", tc24, 0);
    end
    ld24 = 1; ldh24 = 3; ldl24 = 0; tick();
    ld24 = 0;
    check("pre_rst_err", err24, 1);
    nCR = 0; #2;
    check("arst_val", {h24, l24}, 0);
    check("arst_err", err24, 0);
    check("arst_co", co24, 0);
    #8;
    check("arst_hold", {h24, l24}, 0);
    nCR = 1;
    ld60 = 1; ldh60 = 5; ldl60 = 8; tick();
    check("m60_ld", {h60, l60}, 8'h58);
    ld60 = 0; en60 = 1; up60 = 1; #1;
    check("m60_tc58", tc60, 0);
    tick();
    check("m60_59", {h60, l60}, 8'h59);
    check("m60_tc59", tc60, 1);
    check("hr_pre", {hh, hl}, 8'h00);
    tick();
    check("m60_00", {h60, l60}, 8'h00);
    check("m60_co", co60, 1);
    check("hr_step", {hh, hl}, 8'h01);
    tick();
    check("m60_01", {h60, l60}, 8'h01);
    check("m60_co0", co60, 0);
    check("hr_once", {hh, hl}, 8'h01);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
